pc_next_unit: RTL and testbench

//  Next-PC generator for the RV32I pipeline. Owns the fetch PC register and advances it by 4 per accepted fetch.

---
 rtl/pc_next_unit.sv | 204 ++++++++++++++++++++
 tb/tb_pc_next_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC generator for the RV32I pipeline.
// Owns the fetch PC register. It advances the PC by 4 for each fetch accepted through the pc_valid_o/pc_ready_i handshake.
// It also applies EX-stage redirects (taken BRANCH, JAL, JALR) and trap redirects, and raises a fault on misaligned targets.
//
// Optional feature macro: PC_NEXT_RAS_EN. When defined, a RAS_DEPTH-entry circular return-address stack provides prediction hints.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   opcode_i                EX opcode
//   jtype_i/btype_i/itype_i EX immediates
//   rs1_i                   EX rs1 data
//   rd_idx_i, rs1_idx_i     EX register indices (return-address link detection)
//   x_pc_i, x_valid_i       EX instruction PC and valid
//   x_br_i                  EX branch condition
//   trap_i, mtvec_i         trap request pulse and trap vector
//   pc_o, pc_valid_o        fetch PC and its valid
//   pc_ready_i              fetch accepts pc_o
//   redirect_o              combinational flush pulse
//   misalign_o, bad_addr_o  misaligned-target fault and its address
//   ras_pred_o, ras_hit_o   return-address stack top and non-empty hint
module pc_next_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [6:0]      opcode_i,
    input  logic [XLEN-1:0] jtype_i,
    input  logic [XLEN-1:0] btype_i,
    input  logic [XLEN-1:0] itype_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [4:0]      rd_idx_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [XLEN-1:0] x_pc_i,
    input  logic            x_valid_i,
    input  logic            x_br_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] mtvec_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o,
    output logic [XLEN-1:0] ras_pred_o,
    output logic            ras_hit_o
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;

    logic            is_br, is_jal, is_jalr;
    logic            in_run, rq, redirect, tgt_misalign;
    logic [XLEN-1:0] tgt, jalr_sum;

    // Redirect request decode and target computation
    always_comb begin
        is_br    = (opcode_i == OP_BRANCH);
        is_jal   = (opcode_i == OP_JAL);
        is_jalr  = (opcode_i == OP_JALR);
        in_run   = (state_q == ST_RUN);
        rq       = x_valid_i & (is_jal | is_jalr | (is_br & x_br_i));
        jalr_sum = rs1_i + itype_i;
        tgt      = x_pc_i + btype_i;
        if (is_jal) begin
            tgt = x_pc_i + jtype_i;
        end else if (is_jalr) begin
            tgt = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        end
        tgt_misalign = |tgt[1:0];
        // A trap in the same cycle wins and drops the redirect
        redirect     = in_run & rq & ~trap_i;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect && tgt_misalign) state_d = ST_FAULT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase
        if (trap_i) begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs
    always_comb begin
        pc_valid_o = (state_q == ST_RUN);
        misalign_o = (state_q == ST_FAULT);
        redirect_o = redirect;
    end

    // PC and fault address: trap > redirect > advance > hold
    always_comb begin
        pc_d  = pc_q;
        bad_d = bad_q;
        if (trap_i) begin
            pc_d = mtvec_i & {{(XLEN-2){1'b1}}, 2'b00};
        end else if (redirect) begin
            if (tgt_misalign) begin
                bad_d = tgt;
            end else begin
                pc_d = tgt;
            end
        end else if (in_run && pc_ready_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= RESET_VEC;
            bad_q <= '0;
        end else begin
            pc_q  <= pc_d;
            bad_q <= bad_d;
        end
    end

    assign pc_o       = pc_q;
    assign bad_addr_o = bad_q;

`ifdef PC_NEXT_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_a;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_a;
    logic             rd_link, rs1_link, ras_upd, ras_push, ras_pop;

    // Stack control: an optional pop is applied first, followed by an optional push
    always_comb begin
        rd_link  = (rd_idx_i == 5'd1) | (rd_idx_i == 5'd5);
        rs1_link = (rs1_idx_i == 5'd1) | (rs1_idx_i == 5'd5);
        ras_upd  = redirect & (is_jal | is_jalr);
        ras_push = ras_upd & rd_link;
        ras_pop  = ras_upd & is_jalr & rs1_link & ~(rd_link & (rd_idx_i == rs1_idx_i));
        top_a    = top_q;
        cnt_a    = cnt_q;
        if (ras_pop && (cnt_q != '0)) begin
            top_a = top_q - PTR_W'(1);
            cnt_a = cnt_q - CNT_W'(1);
        end
        top_d = top_a;
        cnt_d = cnt_a;
        if (ras_push) begin
            top_d = top_a + PTR_W'(1);
            // A push onto a full stack overwrites the oldest entry
            cnt_d = (cnt_a == CNT_W'(RAS_DEPTH)) ? cnt_a : cnt_a + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            top_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (ras_push) begin
                ras_q[top_d] <= x_pc_i + XLEN'(4);
            end
        end
    end

    assign ras_pred_o = ras_q[top_q];
    assign ras_hit_o  = (cnt_q != '0);
`else
    // Link indices only feed the stack; keep them referenced
    logic unused_idx;
    assign unused_idx = ^{rd_idx_i, rs1_idx_i};
    assign ras_pred_o = '0;
    assign ras_hit_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed, table-driven bench for pc_next_unit (RESET_VEC = 0x100)
module tb_pc_next_unit;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [31:0] JUNK     = 32'h0000_0800;

    logic        clk, rst;
    logic [6:0]  opcode;
    logic [31:0] jtype, btype, itype, rs1, x_pc, mtvec;
    logic [4:0]  rd_idx, rs1_idx;
    logic        x_valid, x_br, trap, pc_ready;
    logic [31:0] pc, bad_addr, ras_pred;
    logic        pc_valid, redirect, misalign, ras_hit;

    int n_cmp = 0;
    int n_err = 0;

    pc_next_unit #(
        .XLEN(32), .RESET_VEC(32'h0000_0100), .RAS_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode),
        .jtype_i(jtype), .btype_i(btype), .itype_i(itype), .rs1_i(rs1),
        .rd_idx_i(rd_idx), .rs1_idx_i(rs1_idx), .x_pc_i(x_pc),
        .x_valid_i(x_valid), .x_br_i(x_br), .trap_i(trap), .mtvec_i(mtvec),
        .pc_o(pc), .pc_valid_o(pc_valid), .pc_ready_i(pc_ready),
        .redirect_o(redirect), .misalign_o(misalign), .bad_addr_o(bad_addr),
        .ras_pred_o(ras_pred), .ras_hit_o(ras_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic        xv;
        logic        br;
        logic        rdy;
        logic [31:0] xpc;
        logic [31:0] imm;
        logic [31:0] r1;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        opcode = OP_ALU; jtype = JUNK; btype = JUNK; itype = JUNK; rs1 = JUNK;
        x_pc = 32'h0000_7000; rd_idx = 5'd0; rs1_idx = 5'd0;
        x_valid = 1'b0; x_br = 1'b0; trap = 1'b0; mtvec = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_jal(input logic [31:0] from, input logic [31:0] off, input logic [4:0] rd);
        opcode = OP_JAL; x_valid = 1'b1; x_pc = from; jtype = off; rd_idx = rd;
    endtask

    task automatic drive_jalr(input logic [31:0] base, input logic [4:0] rd, input logic [4:0] r1i);
        opcode = OP_JALR; x_valid = 1'b1; rs1 = base; itype = 32'h0; rd_idx = rd; rs1_idx = r1i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{OP_BRANCH, 1'b1, 1'b1, 1'b0, 32'h200, 32'hFFFF_FFF8, JUNK, 1'b1, 32'h1F8};
        vecs[1] = '{OP_BRANCH, 1'b1, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFF8, JUNK, 1'b0, 32'h1F8};
        vecs[2] = '{OP_JALR,   1'b1, 1'b0, 1'b0, 32'h7000, 32'h0, 32'h301, 1'b1, 32'h300};
        vecs[3] = '{OP_JAL,    1'b1, 1'b0, 1'b0, 32'h400, 32'h100, JUNK, 1'b1, 32'h500};
        vecs[4] = '{OP_JALR,   1'b1, 1'b0, 1'b0, 32'h7000, 32'hFFFF_FFFC, 32'h1000, 1'b1, 32'hFFC};
        vecs[5] = '{OP_BRANCH, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40, JUNK, 1'b0, 32'hFFC};
        vecs[6] = '{OP_ALU,    1'b1, 1'b1, 1'b0, 32'h200, 32'h40, JUNK, 1'b0, 32'hFFC};
        vecs[7] = '{OP_BRANCH, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, JUNK, 1'b1, 32'h10};
        vecs[8] = '{OP_JAL,    1'b1, 1'b0, 1'b1, 32'h10, 32'h30, JUNK, 1'b1, 32'h40};
        vecs[9] = '{OP_JAL,    1'b0, 1'b0, 1'b1, 32'h10, 32'h30, JUNK, 1'b0, 32'h44};

        clk = 1'b0; rst = 1'b1; pc_ready = 1'b0;
        clear_in();
        tick(); tick();
        chk("reset_pc", pc, 32'h100);
        chk("reset_valid", 32'(pc_valid), 32'd0);
        chk("reset_redirect", 32'(redirect), 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        chk("reset_bad_addr", bad_addr, 32'd0);
        chk("reset_ras_hit", 32'(ras_hit), 32'd0);

        // Boot, then sequential fetch
        rst = 1'b0; pc_ready = 1'b1;
        tick();
        chk("boot_pc", pc, 32'h100);
        chk("boot_valid", 32'(pc_valid), 32'd1);
        tick(); chk("seq_pc1", pc, 32'h104);
        tick(); chk("seq_pc2", pc, 32'h108);

        // Handshake stall
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_pc", pc, 32'h108);
        end

        // Wrap at the top of the address space
        drive_jal(32'h0, 32'hFFFF_FFFC, 5'd0);
        tick(); clear_in();
        chk("wrap_setup_pc", pc, 32'hFFFF_FFFC);
        pc_ready = 1'b1;
        tick(); pc_ready = 1'b0;
        chk("wrap_pc", pc, 32'h0);

        // Table-driven redirect vectors
        for (int i = 0; i < 10; i++) begin
            clear_in();
            opcode = vecs[i].op; x_valid = vecs[i].xv; x_br = vecs[i].br;
            pc_ready = vecs[i].rdy; x_pc = vecs[i].xpc;
            if (vecs[i].op == OP_JAL) jtype = vecs[i].imm;
            else if (vecs[i].op == OP_JALR) begin itype = vecs[i].imm; rs1 = vecs[i].r1; end
            else btype = vecs[i].imm;
            #1;
            chk($sformatf("vec%0d_redirect", i), 32'(redirect), 32'(vecs[i].exp_redir));
            tick();
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
        end
        clear_in(); pc_ready = 1'b0;

        // Misaligned JALR, then fault hold, then trap recovery
        drive_jalr(32'h302, 5'd0, 5'd0);
        #1;
        chk("mis_redirect", 32'(redirect), 32'd1);
        tick(); clear_in();
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_bad_addr", bad_addr, 32'h302);
        chk("mis_valid", 32'(pc_valid), 32'd0);
        chk("mis_pc_hold", pc, 32'h44);
        pc_ready = 1'b1;
        tick();
        chk("fault_pc_hold", pc, 32'h44);
        chk("fault_flag_hold", 32'(misalign), 32'd1);
        trap = 1'b1; mtvec = 32'h83;
        tick(); clear_in();
        chk("trap_pc", pc, 32'h80);
        chk("trap_valid", 32'(pc_valid), 32'd1);
        chk("trap_misalign", 32'(misalign), 32'd0);
        pc_ready = 1'b0;

        // Trap beats a simultaneous JAL redirect
        drive_jal(32'h100, 32'h8, 5'd0);
        trap = 1'b1; mtvec = 32'h2000;
        tick(); clear_in();
        chk("trap_vs_jal_pc", pc, 32'h2000);

        // Reset while in FAULT
        drive_jal(32'h100, 32'h2, 5'd0);
        tick(); clear_in();
        chk("fault2_flag", 32'(misalign), 32'd1);
        chk("fault2_bad_addr", bad_addr, 32'h102);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_fault_pc", pc, 32'h100);
        chk("rst_fault_valid", 32'(pc_valid), 32'd0);
        chk("rst_fault_misalign", 32'(misalign), 32'd0);
        chk("rst_fault_bad_addr", bad_addr, 32'd0);
        tick();

`ifdef PC_NEXT_RAS_EN
        // Five calls into a depth-4 stack, then drain with returns
        for (int k = 1; k <= 5; k++) begin
            drive_jal(32'(k * 16), 32'h1000, 5'd1);
            tick(); clear_in();
        end
        chk("ras_pred_full", ras_pred, 32'h54);
        chk("ras_hit_full", 32'(ras_hit), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive_jalr(32'h2000, 5'd0, 5'd1);
            tick(); clear_in();
            chk($sformatf("ras_pop%0d_pred", k), ras_pred, 32'(32'h44 - k * 16));
        end
        drive_jalr(32'h2000, 5'd0, 5'd1);
        tick(); clear_in();
        chk("ras_empty_hit", 32'(ras_hit), 32'd0);
        drive_jalr(32'h2000, 5'd0, 5'd1);
        tick(); clear_in();
        chk("ras_underflow_hit", 32'(ras_hit), 32'd0);
        drive_jal(32'h60, 32'h1000, 5'd1);
        tick(); clear_in();
        chk("ras_repush_pred", ras_pred, 32'h64);
        chk("ras_repush_hit", 32'(ras_hit), 32'd1);
        drive_jalr(32'h2000, 5'd0, 5'd1);
        tick(); clear_in();
        chk("ras_repop_hit", 32'(ras_hit), 32'd0);
`else
        drive_jal(32'h10, 32'h1000, 5'd1);
        tick(); clear_in();
        chk("noras_pred", ras_pred, 32'd0);
        chk("noras_hit", 32'(ras_hit), 32'd0);
        chk("noras_jal_pc", pc, 32'h1010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
